// File: rtl/itlb_tag_array.sv
// Fully-associative ITLB tag store: combinational lookup, victim selection, fill and SFENCE.VMA flush.
// Optional hit/miss performance counters are enabled by defining ITLB_PERF_CNT_EN.
module itlb_tag_array #(
    parameter int ENTRIES = 8,
    parameter int ASID_WD = 9,
    parameter int VPN1_WD = 10,
    parameter int VPN0_WD = 10,
    localparam int IDX_WD = $clog2(ENTRIES),
    localparam int VPN_WD = VPN1_WD + VPN0_WD
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [ASID_WD-1:0] lkp_asid_i,
    input  logic [VPN_WD-1:0]  lkp_vpn_i,
    output logic               hit_o,
    output logic [ENTRIES-1:0] hit_oh_o,
    output logic [IDX_WD-1:0]  hit_idx_o,
    output logic               hit_mega_o,
    input  logic               wr_en_i,
    input  logic [ASID_WD-1:0] wr_asid_i,
    input  logic [VPN_WD-1:0]  wr_vpn_i,
    input  logic               wr_g_i,
    input  logic               wr_mega_i,
    output logic [IDX_WD-1:0]  wr_idx_o,
    output logic               full_o,
    input  logic               flush_i,
    input  logic               flush_asid_vld_i,
    input  logic               flush_vpn_vld_i,
    input  logic [ASID_WD-1:0] flush_asid_i,
    input  logic [VPN_WD-1:0]  flush_vpn_i
`ifdef ITLB_PERF_CNT_EN
    ,
    input  logic               lkp_vld_i,
    output logic [31:0]        hit_cnt_o,
    output logic [31:0]        miss_cnt_o
`endif
);

    logic [ENTRIES-1:0] valid_r, g_r, mega_r;
    logic [ASID_WD-1:0] asid_r [ENTRIES];
    logic [VPN1_WD-1:0] vpn1_r [ENTRIES];
    logic [VPN0_WD-1:0] vpn0_r [ENTRIES];
    logic [IDX_WD-1:0]  rr_r;

    logic [ENTRIES-1:0] hit_oh_s, wr_match_s, flush_sel_s, valid_nxt_s;
    logic [IDX_WD-1:0]  hit_idx_s, wr_idx_s;
    logic               hit_mega_s, use_rr_s;

    // Megapage entries ignore vpn0; global entries ignore the ASID.
    function automatic logic entry_match(
        input logic vld, input logic g, input logic mega,
        input logic [ASID_WD-1:0] e_asid, input logic [ASID_WD-1:0] q_asid,
        input logic [VPN1_WD-1:0] e_v1,   input logic [VPN1_WD-1:0] q_v1,
        input logic [VPN0_WD-1:0] e_v0,   input logic [VPN0_WD-1:0] q_v0);
        return vld & ((e_asid == q_asid) | g) & (e_v1 == q_v1) & (mega | (e_v0 == q_v0));
    endfunction

    // Per-entry match vectors for lookup, refill and flush.
    always_comb begin
        hit_oh_s    = '0;
        wr_match_s  = '0;
        flush_sel_s = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            hit_oh_s[i] = entry_match(valid_r[i], g_r[i], mega_r[i], asid_r[i], lkp_asid_i,
                                      vpn1_r[i], lkp_vpn_i[VPN_WD-1:VPN0_WD],
                                      vpn0_r[i], lkp_vpn_i[VPN0_WD-1:0]);
            wr_match_s[i] = entry_match(valid_r[i], g_r[i], mega_r[i], asid_r[i], wr_asid_i,
                                        vpn1_r[i], wr_vpn_i[VPN_WD-1:VPN0_WD],
                                        vpn0_r[i], wr_vpn_i[VPN0_WD-1:0]);
            case ({flush_asid_vld_i, flush_vpn_vld_i})
                2'b00:   flush_sel_s[i] = 1'b1;
                2'b10:   flush_sel_s[i] = (asid_r[i] == flush_asid_i) & ~g_r[i];
                2'b01:   flush_sel_s[i] = (vpn1_r[i] == flush_vpn_i[VPN_WD-1:VPN0_WD]) &
                                          (mega_r[i] | (vpn0_r[i] == flush_vpn_i[VPN0_WD-1:0]));
                2'b11:   flush_sel_s[i] = (asid_r[i] == flush_asid_i) & ~g_r[i] &
                                          (vpn1_r[i] == flush_vpn_i[VPN_WD-1:VPN0_WD]) &
                                          (mega_r[i] | (vpn0_r[i] == flush_vpn_i[VPN0_WD-1:0]));
                default: flush_sel_s[i] = 1'b0;
            endcase
        end
    end

    // Lowest matching index wins on multi-hit; scanning downward leaves the lowest one.
    always_comb begin
        hit_idx_s  = '0;
        hit_mega_s = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (hit_oh_s[i]) begin
                hit_idx_s  = IDX_WD'(i);
                hit_mega_s = mega_r[i];
            end else begin
                hit_idx_s  = hit_idx_s;
            end
        end
    end

    // Victim: existing match, then lowest invalid entry, then round-robin pointer.
    always_comb begin
        logic [IDX_WD-1:0] m_idx, inv_idx;
        logic              m_any, inv_any;
        m_idx   = '0;
        inv_idx = '0;
        m_any   = 1'b0;
        inv_any = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (wr_match_s[i]) begin
                m_idx = IDX_WD'(i);
                m_any = 1'b1;
            end else begin
                m_any = m_any;
            end
            if (!valid_r[i]) begin
                inv_idx = IDX_WD'(i);
                inv_any = 1'b1;
            end else begin
                inv_any = inv_any;
            end
        end
        if (m_any) begin
            wr_idx_s = m_idx;
            use_rr_s = 1'b0;
        end else if (inv_any) begin
            wr_idx_s = inv_idx;
            use_rr_s = 1'b0;
        end else begin
            wr_idx_s = rr_r;
            use_rr_s = 1'b1;
        end
    end

    // Flush acts on the pre-edge state, then the write sets its entry valid.
    always_comb begin
        valid_nxt_s = flush_i ? (valid_r & ~flush_sel_s) : valid_r;
        if (wr_en_i) begin
            valid_nxt_s[wr_idx_s] = 1'b1;
        end else begin
            valid_nxt_s = valid_nxt_s;
        end
    end

    // Tag state and round-robin pointer update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_r <= '0;
            g_r     <= '0;
            mega_r  <= '0;
            rr_r    <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                asid_r[i] <= '0;
                vpn1_r[i] <= '0;
                vpn0_r[i] <= '0;
            end
        end else begin
            valid_r <= valid_nxt_s;
            if (wr_en_i) begin
                asid_r[wr_idx_s] <= wr_asid_i;
                vpn1_r[wr_idx_s] <= wr_vpn_i[VPN_WD-1:VPN0_WD];
                vpn0_r[wr_idx_s] <= wr_vpn_i[VPN0_WD-1:0];
                g_r[wr_idx_s]    <= wr_g_i;
                mega_r[wr_idx_s] <= wr_mega_i;
                if (use_rr_s) begin
                    rr_r <= rr_r + IDX_WD'(1);
                end
            end
        end
    end

    assign hit_o      = |hit_oh_s;
    assign hit_oh_o   = hit_oh_s;
    assign hit_idx_o  = hit_idx_s;
    assign hit_mega_o = hit_mega_s;
    assign wr_idx_o   = wr_idx_s;
    assign full_o     = &valid_r;

`ifdef ITLB_PERF_CNT_EN
    logic [31:0] hit_cnt_r, miss_cnt_r;

    // Saturating hit/miss counters; flush has no effect on them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else if (lkp_vld_i) begin
            if (hit_o) begin
                if (hit_cnt_r != 32'hFFFF_FFFF) hit_cnt_r <= hit_cnt_r + 32'd1;
            end else begin
                if (miss_cnt_r != 32'hFFFF_FFFF) miss_cnt_r <= miss_cnt_r + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_r;
    assign miss_cnt_o = miss_cnt_r;
`endif

endmodule
